// File: rtl/mem_map_pkg.sv
// Shared memory map and arbiter state encoding for the fetch/data memory arbiter,
// used by the control unit and by the testbench.
package mem_map_pkg;

    localparam logic [63:0] IM_TOP_DEF  = 64'h2000;
    localparam logic [63:0] DM_BASE_DEF = 64'h2000;
    localparam logic [63:0] DM_TOP_DEF  = 64'hA000;

    localparam int IM_IDX_W = 11;
    localparam int DM_IDX_W = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        D_ACC  = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational decode of a latched byte address into instruction/data memory
// indices, plus legality checks for a fetch or a data access.
module mem_region_decode
    import mem_map_pkg::*;
#(
    parameter logic [63:0] IM_TOP  = IM_TOP_DEF,
    parameter logic [63:0] DM_BASE = DM_BASE_DEF,
    parameter logic [63:0] DM_TOP  = DM_TOP_DEF
) (
    input  logic [63:0]         addr,
    output logic                fetch_ok,
    output logic                data_ok,
    output logic [IM_IDX_W-1:0] im_idx,
    output logic [DM_IDX_W-1:0] dm_idx
);

    assign fetch_ok = (addr < IM_TOP) && (addr[1:0] == 2'b00);
    assign data_ok  = (addr >= DM_BASE) && (addr < DM_TOP) && (addr[2:0] == 3'b000);

    assign im_idx = addr[IM_IDX_W+1:2];
    // DM_BASE is doubleword aligned, so the low three bits never borrow.
    assign dm_idx = addr[DM_IDX_W+2:3] - DM_BASE[DM_IDX_W+2:3];

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one access slot between instruction fetch
// and data load/store ports; every transaction takes IDLE -> ACC -> RESP.
module mem_arbiter
    import mem_map_pkg::*;
#(
    parameter logic [63:0] IM_TOP  = IM_TOP_DEF,
    parameter logic [63:0] DM_BASE = DM_BASE_DEF,
    parameter logic [63:0] DM_TOP  = DM_TOP_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [63:0]         if_addr,
    output logic                if_ack,
    output logic [31:0]         if_rdata,
    output logic                if_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [63:0]         d_addr,
    input  logic [63:0]         d_wdata,
    output logic                d_ack,
    output logic [63:0]         d_rdata,
    output logic                d_err,
    output logic [IM_IDX_W-1:0] im_addr,
    input  logic [31:0]         im_rdata,
    output logic [DM_IDX_W-1:0] dm_addr,
    output logic                dm_we,
    output logic [63:0]         dm_wdata,
    input  logic [63:0]         dm_rdata
);

    arb_state_t          state_q, state_d;
    req_id_t             id_q;
    req_id_t             last_q;
    logic [63:0]         addr_q;
    logic [63:0]         wdata_q;
    logic                we_q;
    logic [63:0]         rdata_q;
    logic                err_q;

    logic                gnt_d, gnt_if;
    logic                fetch_ok, data_ok;
    logic [IM_IDX_W-1:0] im_idx;
    logic [DM_IDX_W-1:0] dm_idx;

    mem_region_decode #(
        .IM_TOP  (IM_TOP),
        .DM_BASE (DM_BASE),
        .DM_TOP  (DM_TOP)
    ) u_decode (
        .addr     (addr_q),
        .fetch_ok (fetch_ok),
        .data_ok  (data_ok),
        .im_idx   (im_idx),
        .dm_idx   (dm_idx)
    );

    // last_q remembers the winner of the last contested grant only, so an
    // uncontested transaction never shifts the round-robin order.
    assign gnt_d  = d_req && (!if_req || (last_q == REQ_IF));
    assign gnt_if = if_req && !gnt_d;

    always_comb begin
        state_d = state_q;
        im_addr = '0;
        dm_addr = '0;
        dm_we   = 1'b0;
        if_ack  = 1'b0;
        d_ack   = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_d)       state_d = D_ACC;
                else if (gnt_if) state_d = IF_ACC;
            end
            IF_ACC: begin
                im_addr = im_idx;
                state_d = RESP;
            end
            D_ACC: begin
                dm_addr = dm_idx;
                dm_we   = we_q && data_ok;
                state_d = RESP;
            end
            RESP: begin
                if_ack  = (id_q == REQ_IF);
                d_ack   = (id_q == REQ_D);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= REQ_IF;
            last_q  <= REQ_IF;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && (gnt_d || gnt_if)) begin
                id_q <= gnt_d ? REQ_D : REQ_IF;
                if (if_req && d_req) last_q <= gnt_d ? REQ_D : REQ_IF;
            end
            if (state_q == IF_ACC) begin
                rdata_q <= fetch_ok ? {32'b0, im_rdata} : 64'b0;
                err_q   <= !fetch_ok;
            end
            if (state_q == D_ACC) begin
                rdata_q <= (data_ok && !we_q) ? dm_rdata : 64'b0;
                err_q   <= !data_ok;
            end
        end
    end

    // Request payload is captured every IDLE cycle; only the grant edge matters.
    always_ff @(posedge clk) begin
        if (state_q == IDLE) begin
            addr_q  <= gnt_d ? d_addr : if_addr;
            we_q    <= gnt_d && d_we;
            wdata_q <= d_wdata;
        end
    end

    assign dm_wdata = wdata_q;
    assign if_rdata = rdata_q[31:0];
    assign d_rdata  = rdata_q;
    assign if_err   = if_ack && err_q;
    assign d_err    = d_ack && err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter IM_TOP, default 64'h2000, exclusive upper byte bound of instruction region [0, IM_TOP).
REQ-002 SHALL have parameter DM_BASE, default 64'h2000, inclusive lower byte bound of data region.
REQ-003 SHALL have parameter DM_TOP, default 64'hA000, exclusive upper byte bound of data region (4096 x 64-bit).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port if_req  in  1  fetch request; held high until if_ack.
REQ-007 SHALL have port if_addr  in  64  fetch byte address; stable while if_req is high.
REQ-008 SHALL have port if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port if_rdata  out  32  instruction word; valid when if_ack is high.
REQ-010 SHALL have port if_err  out  1  fetch fault; valid when if_ack is high.
REQ-011 SHALL have port d_req  in  1  data request; held high until d_ack.
REQ-012 SHALL have port d_we  in  1  1 = store, 0 = load.
REQ-013 SHALL have port d_addr  in  64  data byte address.
REQ-014 SHALL have port d_wdata  in  64  store data.
REQ-015 SHALL have port d_ack  out  1  one-cycle data completion pulse.
REQ-016 SHALL have port d_rdata  out  64  load data; valid when d_ack is high.
REQ-017 SHALL have port d_err  out  1  data fault; valid when d_ack is high.
REQ-018 SHALL have port im_addr  out  11  instruction-memory word index.
REQ-019 SHALL have port im_rdata  in  32  instruction-memory combinational read data.
REQ-020 SHALL have port dm_addr  out  12  data-memory doubleword index.
REQ-021 SHALL have port dm_we  out  1  data-memory write enable, sampled at clk edge.
REQ-022 SHALL have port dm_wdata  out  64  data-memory write data.
REQ-023 SHALL have port dm_rdata  in  64  data-memory combinational read data.

Function
REQ-024 FSM states SHALL be IDLE, IF_ACC, D_ACC, RESP; single transaction outstanding.
REQ-025 In IDLE with any request: grant, latch address/we/wdata/requester id, go to IF_ACC or D_ACC next cycle.
REQ-026 Simultaneous if_req and d_req in IDLE: round-robin; grant the requester not granted last; after reset data wins first.
REQ-027 IF_ACC: im_addr = latched addr[12:2]; capture im_rdata into response register; go to RESP.
REQ-028 D_ACC: dm_addr = (latched addr - DM_BASE)[14:3]; dm_we high exactly this cycle for a legal store; load captures dm_rdata; go to RESP.
REQ-029 RESP: assert granted requester's ack for exactly one cycle with registered rdata/err; return to IDLE; latency request-accepted-cycle N -> ack at N+2.
REQ-030 New request SHALL be accepted no earlier than the cycle after RESP (one transaction per 3 cycles max).
REQ-031 Fetch fault: if_addr >= IM_TOP or if_addr[1:0] != 0 -> if_err=1, if_rdata=0.
REQ-032 Data fault: d_addr outside [DM_BASE, DM_TOP), or d_addr[2:0] != 0 -> d_err=1, d_rdata=0, dm_we never asserted.
REQ-033 Store ack SHALL return d_rdata=0, d_err=0.
REQ-034 dm_we SHALL be 0 in every state except D_ACC of a legal store; im_addr/dm_addr 0 when not accessing.
REQ-035 Request dropped before ack: transaction still completes; ack pulse still issued.

Reset
REQ-036 Reset SHALL force IDLE, all acks/errs/dm_we 0, rdata registers 0, round-robin pointer to "fetch last".
REQ-037 Reset mid-transaction SHALL abort it immediately, no ack, no memory write after assertion.

Structure
REQ-038 Region bounds and FSM state encoding SHALL live in shared package mem_map_pkg for reuse by control unit and testbench.
REQ-039 Address decode/fault check SHALL be sub-module mem_region_decode (combinational); arbiter FSM in mem_arbiter.

Verification
REQ-040 if_req, if_addr=0x10, im_rdata=0x00500093 -> if_ack at N+2, if_rdata=0x00500093, if_err=0.
REQ-041 d_req store d_addr=0x2008, d_wdata=0xDEADBEEF -> dm_we one cycle with dm_addr=1; load 0x2008 -> d_rdata=0xDEADBEEF.
REQ-042 if_req and d_req same cycle, held -> data acked first, fetch acked 3 cycles later; repeat -> fetch first.
REQ-043 d_addr=0x1000 store, d_addr=0x2004 load, if_addr=0x2002 -> d_err=1 (x2), if_err=1, dm_we never high.
REQ-044 reset asserted during D_ACC of store -> no d_ack, dm_we low, FSM IDLE; next fetch completes normally.
